// File: rtl/me_msad_tracker.sv
// Row-batched minimum-SAD tracker: tree-reduces each candidate row (stage 1) and folds it into
// a running minimum over ROWS search rows (stage 2), with optional threshold early termination.
module me_msad_tracker #(
   parameter int CANDIDATES    = 16,
   parameter int SAD_BIT_WIDTH = 14,
   parameter int ROWS          = 17,
   parameter int COL_BITS      = 5,
   parameter int ROW_BITS      = 5
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start_i,
   input  logic                                sad_valid_i,
   input  logic [CANDIDATES*SAD_BIT_WIDTH-1:0] sad_batch_i,
   input  logic [COL_BITS-1:0]                 col_base_i,
   input  logic [SAD_BIT_WIDTH-1:0]            thresh_i,
   output logic                                busy_o,
   output logic [SAD_BIT_WIDTH-1:0]            msad_o,
   output logic [COL_BITS-1:0]                 msad_column_o,
   output logic [ROW_BITS-1:0]                 msad_row_o,
   output logic                                data_valid_o,
   output logic                                early_term_o
);

   localparam int LEVELS = $clog2(CANDIDATES);
   localparam int NLEAF  = 1 << LEVELS;
   localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

   typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DRAIN} state_t;

   state_t                     state_q;
   logic [ROW_BITS-1:0]        row_cnt_q;
   logic [SAD_BIT_WIDTH-1:0]   thresh_q;

   logic                       s1_valid_q;
   logic [SAD_BIT_WIDTH-1:0]   s1_val_q;
   logic [COL_BITS-1:0]        s1_col_q;
   logic [ROW_BITS-1:0]        s1_row_q;

   logic [SAD_BIT_WIDTH-1:0]   min_val_q, min_val_d;
   logic [COL_BITS-1:0]        min_col_q, min_col_d;
   logic [ROW_BITS-1:0]        min_row_q, min_row_d;

   logic                       busy_q, data_valid_q, early_term_q;
   logic [SAD_BIT_WIDTH-1:0]   msad_q;
   logic [COL_BITS-1:0]        msad_col_q;
   logic [ROW_BITS-1:0]        msad_row_q;

   // Binary min tree; pad leaves hold all-ones on the right so real columns win any tie.
   for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
      localparam int NODES = NLEAF >> l;
      logic [SAD_BIT_WIDTH-1:0] val [NODES];
      logic [LEVELS-1:0]        idx [NODES];
      for (genvar n = 0; n < NODES; n++) begin : g_node
         if (l == 0) begin : g_leaf
            if (n < CANDIDATES) begin : g_real
               assign val[n] = sad_batch_i[n*SAD_BIT_WIDTH +: SAD_BIT_WIDTH];
            end else begin : g_pad
               assign val[n] = '1;
            end
            assign idx[n] = LEVELS'(n);
         end else begin : g_cmp
            logic pick_right;
            assign pick_right = g_lvl[l-1].val[2*n+1] < g_lvl[l-1].val[2*n];
            assign val[n] = pick_right ? g_lvl[l-1].val[2*n+1] : g_lvl[l-1].val[2*n];
            assign idx[n] = pick_right ? g_lvl[l-1].idx[2*n+1] : g_lvl[l-1].idx[2*n];
         end
      end
   end

   logic [SAD_BIT_WIDTH-1:0] tree_val;
   logic [COL_BITS-1:0]      tree_col;
   assign tree_val = g_lvl[LEVELS].val[0];
   assign tree_col = col_base_i + COL_BITS'(g_lvl[LEVELS].idx[0]);

   logic accept, take_s1, early_hit, last_row;
   assign accept    = (state_q == S_SEARCH) && sad_valid_i;
   assign take_s1   = (s1_row_q == '0) || (s1_val_q < min_val_q);
   assign early_hit = (thresh_q != '0) && (s1_val_q <= thresh_q);
   assign last_row  = (s1_row_q == LAST_ROW);

   always_comb begin
      min_val_d = min_val_q;
      min_col_d = min_col_q;
      min_row_d = min_row_q;
      if (take_s1) begin
         min_val_d = s1_val_q;
         min_col_d = s1_col_q;
         min_row_d = s1_row_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         row_cnt_q    <= '0;
         thresh_q     <= '0;
         s1_valid_q   <= 1'b0;
         s1_val_q     <= '0;
         s1_col_q     <= '0;
         s1_row_q     <= '0;
         min_val_q    <= '0;
         min_col_q    <= '0;
         min_row_q    <= '0;
         busy_q       <= 1'b0;
         data_valid_q <= 1'b0;
         early_term_q <= 1'b0;
         msad_q       <= '0;
         msad_col_q   <= '0;
         msad_row_q   <= '0;
      end else begin
         data_valid_q <= 1'b0;
         early_term_q <= 1'b0;
         if (data_valid_q) busy_q <= 1'b0;

         if (start_i) begin
            state_q    <= S_SEARCH;
            row_cnt_q  <= '0;
            thresh_q   <= thresh_i;
            s1_valid_q <= 1'b0;
            min_val_q  <= '0;
            min_col_q  <= '0;
            min_row_q  <= '0;
            busy_q     <= 1'b1;
         end else begin
            s1_valid_q <= accept;
            if (accept) begin
               s1_val_q  <= tree_val;
               s1_col_q  <= tree_col;
               s1_row_q  <= row_cnt_q;
               row_cnt_q <= row_cnt_q + 1'b1;
               if (row_cnt_q == LAST_ROW) state_q <= S_DRAIN;
            end
            // NOTE: the later nonblocking assignments below win, so a finishing row
            // discards whatever stage 1 is loading this same cycle.
            if (s1_valid_q) begin
               min_val_q <= min_val_d;
               min_col_q <= min_col_d;
               min_row_q <= min_row_d;
               if (early_hit || last_row) begin
                  msad_q       <= min_val_d;
                  msad_col_q   <= min_col_d;
                  msad_row_q   <= min_row_d;
                  data_valid_q <= 1'b1;
                  early_term_q <= early_hit;
                  state_q      <= S_IDLE;
                  s1_valid_q   <= 1'b0;
               end
            end
         end
      end
   end

   assign busy_o        = busy_q;
   assign msad_o        = msad_q;
   assign msad_column_o = msad_col_q;
   assign msad_row_o    = msad_row_q;
   assign data_valid_o  = data_valid_q;
   assign early_term_o  = early_term_q;

endmodule

// File: doc/me_msad_tracker.md
# me_msad_tracker

Parametrised successor to the fixed 16-candidate minimum/post-processing path of the motion-estimation engine. Accepts one row of candidate SADs per cycle, reduces each row to its minimum through a two-stage pipeline, and tracks the running minimum over a configurable number of search rows. It reports MSAD with its column and row, supports a column base offset for multi-pass windows, and adds threshold-based early termination. Sits between the SAD adder stage and the block-level result output.

## Interface
- CANDIDATES, 16: SADs per row (columns per batch), ≥2
- SAD_BIT_WIDTH, 14: width of each SAD
- ROWS, 17: search rows per block, 1..2^ROW_BITS
- COL_BITS, 5: width of column coordinate, 2^COL_BITS ≥ CANDIDATES
- ROW_BITS, 5: width of row coordinate

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  begin a new block search; one-cycle pulse
- sad_valid_i  in  1  sad_batch_i/col_base_i valid this cycle
- sad_batch_i  in  CANDIDATES*SAD_BIT_WIDTH  element k at [(k+1)*SAD_BIT_WIDTH-1 : k*SAD_BIT_WIDTH] = column k
- col_base_i  in  COL_BITS  column offset added to k, sampled with the batch
- thresh_i  in  SAD_BIT_WIDTH  early-termination threshold, sampled on start_i; 0 disables
- busy_o  out  1  high from the cycle after start_i until the result pulse
- msad_o  out  SAD_BIT_WIDTH  minimum SAD
- msad_column_o  out  COL_BITS  (col_base + k) mod 2^COL_BITS of the minimum
- msad_row_o  out  ROW_BITS  0-based accepted-row index of the minimum
- data_valid_o  out  1  one-cycle result pulse
- early_term_o  out  1  qualifies data_valid_o: search ended on threshold

## Operation
- States: IDLE, SEARCH, DRAIN.
- IDLE: sad_valid_i ignored. start_i -> SEARCH. Row counter, running minimum, and pipeline valid bits cleared. thresh_i latched.
- SEARCH: each sad_valid_i cycle accepts a batch and tags it with the row counter, which then increments. When the ROWS-th batch is accepted -> DRAIN. sad_valid_i low means a bubble; the counter holds.
- Stage 1, registered: tree minimum of the batch gives value, index k (lowest k wins ties), column = col_base + k (wraps), and row tag.
- Stage 2, registered: the running minimum updates only on strict less-than, so the earliest row wins ties. Row 0 always loads.
- Early termination: thresh ≠ 0 and stage-2 input value ≤ thresh.
  - That row completes the search.
  - Any batch in stage 1 and all later sad_valid_i are discarded.
  - FSM -> IDLE.
  - early_term_o = 1 with the pulse.
- Normal completion: the ROWS-th row leaves stage 2, data_valid_o pulses with early_term_o = 0, FSM -> IDLE.
- start_i in SEARCH/DRAIN: abort. No pulse, pipeline flushed, restart as from IDLE.
- start_i in the same cycle as the result pulse: the result is still reported and the new search starts.
- msad_o / msad_column_o / msad_row_o hold their last result until the next pulse.
- Arithmetic is unsigned compare. No saturation; inputs are trusted in range.

## Timing
- Reset (synchronous): state IDLE, all outputs 0, pipeline valid bits 0.
- Batch accepted in cycle t: stage 1 at t+1, stage 2 at t+2.
- For the last (or terminating) batch at cycle t, data_valid_o is high in cycle t+2 only.
- Back-to-back batches are supported: throughput is one row per cycle.
- Minimum start-to-result latency with no bubbles: start at cycle s, data_valid_o at s+ROWS+2.
- busy_o falls in the cycle after data_valid_o.
- rst overrides start_i and sad_valid_i in the same cycle.

## Test plan
- Defaults, 17 rows of all-500 except row 9 col 3 = 12, col_base 0, thresh 0 -> msad 12, col 3, row 9, early 0, pulse exactly 2 cycles after the 17th batch.
- Ties: row 2 cols 5 and 11 = 7, row 6 col 0 = 7, others 100 -> col 5, row 2.
- Wrap: col_base 24, min at k = 10 -> msad_column_o = 2. Insert 3-cycle bubbles between rows -> same result, counter unaffected.
- Early term: thresh 20, row 4 min = 20 -> pulse 2 cycles after row 4, row 4, early 1. Row 5 already sent is discarded. busy_o low the next cycle, later batches ignored.
- Abort: start_i after row 8 -> no pulse. New 17-row search reports only new data. rst mid-SEARCH -> all outputs 0, IDLE, no pulse.
- Parametrised build CANDIDATES=32, ROWS=4, COL_BITS=6: min at k = 31, row 3 -> col 31, row 3, pulse at start+6.
